// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared state type, hit codes and period helpers for the tone player
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [1:0] HIT_NONE = 2'd0;
  localparam logic [1:0] HIT_HIT  = 2'd1;
  localparam logic [1:0] HIT_MISS = 2'd2;

  function automatic int half_period(input int clk_hz, input int tone_hz);
    return clk_hz / (2 * tone_hz);
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/square_gen.sv
// rtl/square_gen.sv - half-period counter with phase toggle; load restarts in the high phase
module square_gen #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic          en_i,
  input  logic [CW-1:0] half_m1_i,
  output logic          phase_d_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (load_i) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (en_i) begin
      if (cnt_q == half_m1_i) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Exposed as next-state so the registered audio output lines up with the phase.
  assign phase_d_o = phase_d;

endmodule

// File: rtl/hit_tone_player.sv
// rtl/hit_tone_player.sv - turns hit/miss event pulses into PWM tone bursts with a one-deep buffer
module hit_tone_player
  import audio_pkg::*;
#(
  parameter int CLK_HZ   = 25000000,
  parameter int HIT_HZ   = 880,
  parameter int MISS_HZ  = 220,
  parameter int TONE_MS  = 100,
  parameter int GAP_MS   = 20,
  parameter int PWM_BITS = 8,
  parameter int DUTY     = 128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] hit,
  output logic       audioOut,
  output logic       audioEn,
  output logic       chSel,
  output logic [1:0] tone_code,
  output logic       busy
);

  localparam int HALF_HIT  = half_period(CLK_HZ, HIT_HZ);
  localparam int HALF_MISS = half_period(CLK_HZ, MISS_HZ);
  localparam int TONE_CYC  = CLK_HZ / 1000 * TONE_MS;
  localparam int GAP_CYC   = CLK_HZ / 1000 * GAP_MS;
  localparam int HALF_MAX  = (HALF_HIT > HALF_MISS) ? HALF_HIT : HALF_MISS;
  localparam int HW = cnt_width(HALF_MAX);
  localparam int DW = cnt_width(TONE_CYC);
  localparam int GW = cnt_width(GAP_CYC);

  localparam logic [HW-1:0] HIT_M1  = HW'(HALF_HIT - 1);
  localparam logic [HW-1:0] MISS_M1 = HW'(HALF_MISS - 1);
  localparam logic [DW-1:0] TONE_M1 = DW'(TONE_CYC - 1);
  localparam logic [GW-1:0] GAP_M1  = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [PWM_BITS:0] DUTY_V = (PWM_BITS + 1)'(DUTY);

  state_e              state_q, state_d;
  logic [1:0]          code_q, code_d;
  logic [1:0]          pend_q, pend_d;
  logic [DW-1:0]       dur_q, dur_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic                audio_q, audio_d;
  logic                en_q, busy_q;
  logic                ev_valid, burst_end, sq_load, sq_en, phase_next;
  logic [1:0]          next_code, next_pend;
  logic [HW-1:0]       half_m1;

  assign ev_valid = (hit == HIT_HIT) || (hit == HIT_MISS);
  // A buffered code plays first; an event in the same cycle takes over the freed slot.
  assign next_code = (pend_q != HIT_NONE) ? pend_q : (ev_valid ? hit : HIT_NONE);
  assign next_pend = (pend_q != HIT_NONE && ev_valid) ? hit : HIT_NONE;
  assign half_m1   = (code_q == HIT_MISS) ? MISS_M1 : HIT_M1;
  assign pwm_d     = pwm_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    pend_d    = pend_q;
    dur_d     = dur_q;
    gap_d     = gap_q;
    sq_load   = 1'b0;
    sq_en     = 1'b0;
    burst_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (ev_valid) begin
          state_d = PLAY;
          code_d  = hit;
          dur_d   = TONE_M1;
          sq_load = 1'b1;
        end
      end
      PLAY: begin
        sq_en = 1'b1;
        if (ev_valid) pend_d = hit;
        if (dur_q == '0) begin
          if (GAP_CYC > 0) begin
            state_d = GAP;
            gap_d   = GAP_M1;
            code_d  = HIT_NONE;
          end else begin
            burst_end = 1'b1;
          end
        end else begin
          dur_d = dur_q - 1'b1;
        end
      end
      GAP: begin
        if (ev_valid) pend_d = hit;
        if (gap_q == '0) burst_end = 1'b1;
        else gap_d = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (burst_end) begin
      if (next_code != HIT_NONE) begin
        state_d = PLAY;
        code_d  = next_code;
        pend_d  = next_pend;
        dur_d   = TONE_M1;
        sq_load = 1'b1;
      end else begin
        state_d = IDLE;
        code_d  = HIT_NONE;
      end
    end
  end

  assign audio_d = (state_d == PLAY) && phase_next && ({1'b0, pwm_d} < DUTY_V);

  square_gen #(.CW(HW)) u_square (
    .clk      (clk),
    .rst_ni   (reset),
    .load_i   (sq_load),
    .en_i     (sq_en),
    .half_m1_i(half_m1),
    .phase_d_o(phase_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      code_q  <= HIT_NONE;
      pend_q  <= HIT_NONE;
      dur_q   <= '0;
      gap_q   <= '0;
      pwm_q   <= '0;
      audio_q <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pend_q  <= pend_d;
      dur_q   <= dur_d;
      gap_q   <= gap_d;
      pwm_q   <= pwm_d;
      audio_q <= audio_d;
      en_q    <= (state_d == PLAY);
      busy_q  <= (state_d != IDLE) || (pend_d != HIT_NONE);
    end
  end

  assign audioOut  = audio_q;
  assign audioEn   = en_q;
  assign chSel     = 1'b0;
  assign tone_code = code_q;
  assign busy      = busy_q;

endmodule
